// File: rtl/prod_accum.sv
// -----------------------------------------------------------------------------
// prod_accum -- burst accumulator for the 8x8 multiplier product stream.
//
// Sums a burst of unsigned 16-bit products into an ACC_W-bit accumulator.
// A burst ends on the beat carrying in_last. It also ends automatically when
// the beat count reaches 2^LEN_W-1. The result is then presented with a
// valid/ready handshake. Input is stalled (in_ready=0) while a result is pending.
//
// Parameters:
//   ACC_W  accumulator / out_sum width (>= 16), default 24
//   LEN_W  beat-counter width, default 4 (max burst 2^LEN_W-1 beats)
//
// Ports:
//   clk        single clock, rising edge
//   rst        asynchronous, active-high reset
//   in_valid   upstream product beat valid
//   in_prod    16-bit unsigned product
//   in_last    final beat of the burst (qualified by in_valid)
//   in_ready   block can accept a beat (high in IDLE/ACC, low in DONE)
//   out_valid  burst result available (high exactly while in DONE)
//   out_ready  downstream accepts the result
//   out_sum    accumulated sum of the burst
//   out_count  number of beats accumulated
//   out_ovf    sticky overflow flag for the burst
//
// Build option:
//   PROD_ACCUM_SAT_EN  when defined, the accumulator clamps to 2^ACC_W-1 on
//                      overflow. Otherwise it wraps modulo 2^ACC_W. out_ovf
//                      is set in both cases.
// -----------------------------------------------------------------------------
module prod_accum #(
  parameter int ACC_W = 24,
  parameter int LEN_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [15:0]      in_prod,
  input  logic             in_last,
  output logic             in_ready,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
  output logic [LEN_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [LEN_W-1:0] CNT_MAX = '1;

  state_t           state;
  state_t           state_next;

  logic [ACC_W-1:0] acc;
  logic [LEN_W-1:0] cnt;
  logic             ovf;

  logic             take;
  logic [ACC_W:0]   sum_ext;
  logic             carry;
  logic [ACC_W-1:0] acc_add;
  logic [LEN_W-1:0] cnt_inc;

  // A beat moves only on a valid/ready cycle.
  assign take = in_valid && in_ready;

  // The sum is one bit wider than the accumulator, so the carry out of
  // bit ACC_W-1 can be read directly.
  assign sum_ext = (ACC_W+1)'(acc) + (ACC_W+1)'(in_prod);
  assign carry   = sum_ext[ACC_W];
  assign cnt_inc = cnt + LEN_W'(1);

`ifdef PROD_ACCUM_SAT_EN
  // Clamp on carry. Once acc holds all-ones, any nonzero product carries again.
  // A zero product leaves acc unchanged. Either way acc stays at full scale
  // for the rest of the burst.
  assign acc_add = carry ? '1 : sum_ext[ACC_W-1:0];
`else
  // Wrap modulo 2^ACC_W. The lost carry is still recorded in ovf.
  assign acc_add = sum_ext[ACC_W-1:0];
`endif

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. Every flop in this
  // block then samples pre-edge values, whatever the statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every signal written here gets a default first. Otherwise a path
  // that skips an assignment would infer a latch.
  always_comb begin
    state_next = state;
    in_ready   = (state != DONE);
    out_valid  = (state == DONE);

    unique case (state)
      IDLE: begin
        if (take) begin
          state_next = in_last ? DONE : ACC;
        end
      end
      ACC: begin
        // Auto-close when the incremented count reaches the counter maximum.
        if (take) begin
          state_next = (in_last || (cnt_inc == CNT_MAX)) ? DONE : ACC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Accumulator datapath
  // ---------------------------------------------------------------------------
  // acc/cnt/ovf change only on accepted beats. They are therefore held through
  // DONE, and after the handshake they keep their values until the first beat
  // of the next burst overwrites them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
      ovf <= 1'b0;
    end else if (take) begin
      if (state == IDLE) begin
        acc <= ACC_W'(in_prod);
        cnt <= LEN_W'(1);
        ovf <= 1'b0;
      end else begin
        acc <= acc_add;
        cnt <= cnt_inc;
        ovf <= ovf | carry;
      end
    end
  end

  assign out_sum   = acc;
  assign out_count = cnt;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_prod_accum.sv
// -----------------------------------------------------------------------------
// tb_prod_accum -- self-checking bench for prod_accum.
//
// Two instances share all inputs: a 24-bit accumulator and a 16-bit one. The
// 16-bit instance reaches overflow with ordinary bursts. A directed table,
// hand-written reset sequences and randomized bursts are checked against a
// model. The model sums each burst in plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_prod_accum;

`ifdef PROD_ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [15:0] in_prod;
  logic        in_last;
  logic        out_ready;

  logic        in_ready24, out_valid24, out_ovf24;
  logic [23:0] out_sum24;
  logic [3:0]  out_count24;
  logic        in_ready16, out_valid16, out_ovf16;
  logic [15:0] out_sum16;
  logic [3:0]  out_count16;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] burst_q[$];

  always #5 clk = ~clk;

  prod_accum #(.ACC_W(24), .LEN_W(4)) dut24 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_prod(in_prod),
    .in_last(in_last), .in_ready(in_ready24), .out_valid(out_valid24),
    .out_ready(out_ready), .out_sum(out_sum24), .out_count(out_count24),
    .out_ovf(out_ovf24)
  );

  prod_accum #(.ACC_W(16), .LEN_W(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_prod(in_prod),
    .in_last(in_last), .in_ready(in_ready16), .out_valid(out_valid16),
    .out_ready(out_ready), .out_sum(out_sum16), .out_count(out_count16),
    .out_ovf(out_ovf16)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: the burst total in wide arithmetic, then wrap or clamp at width w.
  function automatic void model(input int w, output logic [31:0] s, output bit o);
    longint total = 0;
    longint mx    = (longint'(1) << w) - 1;
    foreach (burst_q[i]) total += longint'(burst_q[i]);
    o = (total > mx);
    if (!o)       s = 32'(total);
    else if (SAT) s = 32'(mx);
    else          s = 32'(total & mx);
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready24"},  32'(in_ready24),  32'd1);
    check({tag, "_out_valid24"}, 32'(out_valid24), 32'd0);
    check({tag, "_out_sum24"},   32'(out_sum24),   32'd0);
    check({tag, "_out_count24"}, 32'(out_count24), 32'd0);
    check({tag, "_out_ovf24"},   32'(out_ovf24),   32'd0);
    check({tag, "_in_ready16"},  32'(in_ready16),  32'd1);
    check({tag, "_out_valid16"}, 32'(out_valid16), 32'd0);
    check({tag, "_out_sum16"},   32'(out_sum16),   32'd0);
  endtask

  task automatic check_done(input string tag, input int n,
                            input logic [31:0] e24, input bit o24,
                            input logic [31:0] e16, input bit o16);
    check({tag, "_out_valid24"}, 32'(out_valid24), 32'd1);
    check({tag, "_in_ready24"},  32'(in_ready24),  32'd0);
    check({tag, "_out_sum24"},   32'(out_sum24),   e24);
    check({tag, "_out_count24"}, 32'(out_count24), 32'(n));
    check({tag, "_out_ovf24"},   32'(out_ovf24),   32'(o24));
    check({tag, "_out_valid16"}, 32'(out_valid16), 32'd1);
    check({tag, "_out_sum16"},   32'(out_sum16),   e16);
    check({tag, "_out_count16"}, 32'(out_count16), 32'(n));
    check({tag, "_out_ovf16"},   32'(out_ovf16),   32'(o16));
  endtask

  // Present burst_q one beat per accepted cycle, with optional idle gaps.
  // Then hold the result for `stall` cycles and finally complete the handshake.
  // out_ready is randomized outside DONE, where it must have no effect.
  task automatic run_burst(input string tag, input bit with_last,
                           input int gap_max, input int stall, input bit stall_valid,
                           input logic [31:0] e24, input bit o24,
                           input logic [31:0] e16, input bit o16);
    int n = burst_q.size();
    for (int i = 0; i < n; i++) begin
      int gaps = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
      for (int g = 0; g < gaps; g++) begin
        @(negedge clk);
        in_valid  = 1'b0;
        in_prod   = 16'($urandom);
        in_last   = 1'($urandom);
        out_ready = 1'($urandom);
      end
      @(negedge clk);
      check({tag, "_beat_in_ready"},  32'(in_ready24 & in_ready16), 32'd1);
      check({tag, "_beat_out_valid"}, 32'(out_valid24 | out_valid16), 32'd0);
      in_valid  = 1'b1;
      in_prod   = burst_q[i];
      in_last   = with_last && (i == n - 1);
      out_ready = 1'($urandom);
    end
    @(negedge clk);
    check_done({tag, "_done"}, n, e24, o24, e16, o16);
    for (int s = 0; s < stall; s++) begin
      in_valid  = stall_valid;
      in_prod   = 16'($urandom);
      in_last   = 1'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      check_done({tag, "_stall"}, n, e24, o24, e16, o16);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_after_out_valid"}, 32'(out_valid24 | out_valid16), 32'd0);
    check({tag, "_after_in_ready"},  32'(in_ready24 & in_ready16),   32'd1);
    out_ready = 1'b0;
  endtask

  typedef struct {
    int          n;
    logic [15:0] prod;
    bit          use_last;
    int          stall;
    logic [31:0] e24;
    bit          o24;
    logic [31:0] e16_wrap;
    logic [31:0] e16_sat;
    bit          o16;
  } vec_t;

  vec_t vecs[7];

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Identical beats per row. Expected sums are n*prod, wrapped or clamped
    // at 16 bits for the narrow instance.
    vecs[0] = '{3,  16'h0180, 1'b1, 0, 32'h000480, 1'b0, 32'h0480, 32'h0480, 1'b0};
    vecs[1] = '{1,  16'hFE01, 1'b1, 5, 32'h00FE01, 1'b0, 32'hFE01, 32'hFE01, 1'b0};
    vecs[2] = '{15, 16'hFE01, 1'b0, 0, 32'h0EE20F, 1'b0, 32'hE20F, 32'hFFFF, 1'b1};
    vecs[3] = '{2,  16'hFE01, 1'b1, 0, 32'h01FC02, 1'b0, 32'hFC02, 32'hFFFF, 1'b1};
    vecs[4] = '{1,  16'h0003, 1'b1, 2, 32'h000003, 1'b0, 32'h0003, 32'h0003, 1'b0};
    vecs[5] = '{15, 16'hFFFF, 1'b1, 0, 32'h0EFFF1, 1'b0, 32'hFFF1, 32'hFFFF, 1'b1};
    vecs[6] = '{4,  16'h0000, 1'b1, 1, 32'h000000, 1'b0, 32'h0000, 32'h0000, 1'b0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_prod   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed table. In the stall rows in_valid is held high: no beat may
    // be consumed while DONE waits for out_ready.
    for (int v = 0; v < 7; v++) begin
      burst_q.delete();
      for (int i = 0; i < vecs[v].n; i++) burst_q.push_back(vecs[v].prod);
      run_burst($sformatf("vec%0d", v), vecs[v].use_last, 0, vecs[v].stall, 1'b1,
                vecs[v].e24, vecs[v].o24,
                SAT ? vecs[v].e16_sat : vecs[v].e16_wrap, vecs[v].o16);
    end

    // Auto-close followed directly by a beat: that beat starts a fresh burst.
    burst_q.delete();
    for (int i = 0; i < 15; i++) burst_q.push_back(16'h0001);
    run_burst("autoclose", 1'b0, 0, 0, 1'b0, 32'd15, 1'b0, 32'd15, 1'b0);
    burst_q.delete();
    burst_q.push_back(16'h0042);
    run_burst("autoclose_next", 1'b1, 0, 0, 1'b0, 32'h42, 1'b0, 32'h42, 1'b0);

    // Reset mid-burst, asserted away from any clock edge.
    @(negedge clk);
    in_valid = 1'b1; in_prod = 16'h1111; in_last = 1'b0;
    @(negedge clk);
    in_prod = 16'h2222;
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk);
    rst = 1'b0;
    burst_q.delete();
    burst_q.push_back(16'h0003);
    run_burst("post_rst", 1'b1, 0, 0, 1'b0, 32'd3, 1'b0, 32'd3, 1'b0);

    // Reset while a result is pending in DONE.
    @(negedge clk);
    in_valid = 1'b1; in_prod = 16'h1234; in_last = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
    check("rst_done_pre_valid", 32'(out_valid24), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_done");
    @(negedge clk);
    rst = 1'b0;

    // Randomized bursts against the model. Some rows favour large products
    // so the 16-bit instance overflows.
    for (int b = 0; b < 60; b++) begin
      int          n = int'($urandom_range(1, 15));
      bit          use_last = (n < 15) ? 1'b1 : 1'($urandom);
      bit          big = 1'($urandom);
      logic [31:0] e24, e16;
      bit          o24, o16;
      burst_q.delete();
      for (int i = 0; i < n; i++)
        burst_q.push_back(big ? 16'($urandom_range(16'hC000, 16'hFFFF)) : 16'($urandom));
      model(24, e24, o24);
      model(16, e16, o16);
      run_burst($sformatf("rand%0d", b), use_last, 2, int'($urandom_range(0, 3)),
                1'($urandom), e24, o24, e16, o16);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
